// File: rtl/varbuf_multi_pkg.sv
// varbuf_multi_pkg: shared state encoding and limits for the multi-channel variable-delay buffer.
package varbuf_multi_pkg;
    typedef enum logic {VARBUF_IDLE, VARBUF_RUN} state_t;
    localparam int VARBUF_MAX_NCH = 8;
endpackage

// File: rtl/varbuf_multi_if.sv
// varbuf_multi_if: control and per-channel data bundle for varbuf_multi.
// The stall signal exists only when VARBUF_STALL_EN is defined.
interface varbuf_multi_if #(parameter int ADDR_W = 6, parameter int DATA_W = 32, parameter int NCH = 2);
    logic run;
    logic clear;
    logic [NCH*ADDR_W-1:0] amount;
    logic [NCH*DATA_W-1:0] in0;
    logic [NCH*DATA_W-1:0] out0;
    logic [NCH-1:0] out_valid;
`ifdef VARBUF_STALL_EN
    logic stall;
    modport master(output run, clear, amount, in0, stall, input out0, out_valid);
    modport slave(input run, clear, amount, in0, stall, output out0, out_valid);
`else
    modport master(output run, clear, amount, in0, input out0, out_valid);
    modport slave(input run, clear, amount, in0, output out0, out_valid);
`endif
endinterface

// File: rtl/varbuf_multi_ram.sv
// varbuf_multi_ram: DEPTH x DATA_W storage, one write port and one registered read port.
module varbuf_multi_ram #(parameter int ADDR_W = 6, parameter int DATA_W = 32) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [1<<ADDR_W];
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/varbuf_multi.sv
// varbuf_multi: NCH-channel programmable delay line (1..DEPTH cycles) with per-channel fill-valid.
// Optional VARBUF_STALL_EN adds a stall input that freezes the whole datapath.
module varbuf_multi
    import varbuf_multi_pkg::*;
#(parameter int ADDR_W = 6, parameter int DATA_W = 32, parameter int NCH = 2) (
    input logic clk,
    input logic rst_n,
    varbuf_multi_if.slave bus
);
    state_t state;
    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W:0] cnt;
    logic [ADDR_W-1:0] amt_q [NCH];
    logic [DATA_W-1:0] byp_q [NCH];
    logic [DATA_W-1:0] rd_q [NCH];
    logic [NCH-1:0] valid;
    logic stall;
    logic adv;
`ifdef VARBUF_STALL_EN
    assign stall = bus.stall;
`else
    assign stall = 1'b0;
`endif
    // run/clear take the cycle over, so no sample is written on a restart edge
    assign adv = state == VARBUF_RUN && !stall && !bus.run && !bus.clear;
    assign bus.out_valid = valid;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= VARBUF_IDLE;
            wptr <= '0;
            cnt <= '0;
            valid <= '0;
            for (int i = 0; i < NCH; i++) begin
                amt_q[i] <= '0;
                byp_q[i] <= '0;
            end
        end else if (bus.clear || bus.run) begin
            state <= bus.clear ? VARBUF_IDLE : VARBUF_RUN;
            wptr <= '0;
            cnt <= '0;
            valid <= '0;
            if (!bus.clear)
                for (int i = 0; i < NCH; i++) amt_q[i] <= bus.amount[i*ADDR_W +: ADDR_W];
        end else if (adv) begin
            wptr <= wptr + 1'b1;
            cnt <= cnt + {{ADDR_W{1'b0}}, !cnt[ADDR_W]};
            for (int i = 0; i < NCH; i++) begin
                valid[i] <= {1'b0, amt_q[i]} <= cnt;
                byp_q[i] <= bus.in0[i*DATA_W +: DATA_W];
            end
        end
    end
    for (genvar c = 0; c < NCH; c++) begin : g_ch
        varbuf_multi_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
            .clk(clk),
            .we(adv),
            .waddr(wptr),
            .wdata(bus.in0[c*DATA_W +: DATA_W]),
            .re(adv),
            .raddr(wptr - amt_q[c]),
            .rdata(rd_q[c])
        );
        // amount 0 skips the RAM so no read-during-write ordering is needed
        assign bus.out0[c*DATA_W +: DATA_W] = valid[c] ? (amt_q[c] == '0 ? byp_q[c] : rd_q[c]) : '0;
    end
endmodule

// File: tb/tb_varbuf_multi.sv
// tb_varbuf_multi: directed + random stimulus for varbuf_multi against a sample-history model.
// Define VARBUF_STALL_EN to also exercise the stall feature.
module tb_varbuf_multi;
    localparam int AW = 6;
    localparam int DW = 32;
    localparam int NC = 2;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic run = 1'b0;
    logic clear = 1'b0;
    logic stall_v = 1'b0;
    logic [NC*AW-1:0] amount = '0;
    logic [NC*DW-1:0] in0 = '0;
    int vecs = 0;
    int errs = 0;
    bit m_run = 1'b0;
    int n = 0;
    int amt_m [NC];
    logic [DW-1:0] hist [NC][0:1023];
    varbuf_multi_if #(.ADDR_W(AW), .DATA_W(DW), .NCH(NC)) bus ();
    assign bus.run = run;
    assign bus.clear = clear;
    assign bus.amount = amount;
    assign bus.in0 = in0;
`ifdef VARBUF_STALL_EN
    assign bus.stall = stall_v;
`endif
    varbuf_multi #(.ADDR_W(AW), .DATA_W(DW), .NCH(NC)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Expected output: sample number n-1-amount of the current run, once that many exist
    task automatic compare();
        for (int c = 0; c < NC; c++) begin
            logic v;
            logic [DW-1:0] d;
            v = m_run && n > amt_m[c];
            d = v ? hist[c][n-1-amt_m[c]] : '0;
            chk($sformatf("out_valid[%0d] n=%0d", c, n), {31'b0, bus.out_valid[c]}, {31'b0, v});
            chk($sformatf("out0[%0d] n=%0d", c, n), bus.out0[c*DW +: DW], d);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n || clear) begin
            m_run = 1'b0;
            n = 0;
        end else if (run) begin
            m_run = 1'b1;
            n = 0;
            for (int c = 0; c < NC; c++) amt_m[c] = int'(amount[c*AW +: AW]);
        end else if (m_run && !stall_v) begin
            for (int c = 0; c < NC; c++) hist[c][n] = in0[c*DW +: DW];
            n++;
        end
        #1;
        compare();
    endtask

    task automatic set_amt(input int a0, input int a1);
        amount = {AW'(a1), AW'(a0)};
    endtask

    task automatic pulse_run();
        run = 1'b1;
        tick();
        run = 1'b0;
    endtask

    task automatic ramp(input int start, input int len);
        for (int i = 0; i < len; i++) begin
            in0 = {DW'(start + i), DW'(start + i)};
            tick();
        end
    endtask

    task automatic rnd(input int len);
        for (int i = 0; i < len; i++) begin
            in0 = {$urandom, $urandom};
            tick();
        end
    endtask

    initial begin
        #1;
        chk("reset out0", bus.out0[DW-1:0], '0);
        chk("reset out_valid", {30'b0, bus.out_valid}, '0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        set_amt(0, 3);
        pulse_run();
        ramp(1, 20);
        set_amt(63, 17);
        pulse_run();
        ramp(1, 200);
        set_amt(5, 1);
        pulse_run();
        rnd(15);
        set_amt(9, 0);
        rnd(15);
        pulse_run();
        rnd(20);
        run = 1'b1;
        clear = 1'b1;
        in0 = {$urandom, $urandom};
        tick();
        run = 1'b0;
        clear = 1'b0;
        rnd(3);
        set_amt($urandom_range(0, 4), $urandom_range(0, 4));
        pulse_run();
        rnd(12);
        rst_n = 1'b0;
        #2;
        chk("async reset out0[0]", bus.out0[DW-1:0], '0);
        chk("async reset out0[1]", bus.out0[2*DW-1:DW], '0);
        chk("async reset out_valid", {30'b0, bus.out_valid}, '0);
        rnd(2);
        rst_n = 1'b1;
        rnd(3);
`ifdef VARBUF_STALL_EN
        set_amt(2, 5);
        pulse_run();
        ramp(100, 10);
        stall_v = 1'b1;
        ramp(500, 5);
        stall_v = 1'b0;
        ramp(110, 12);
        stall_v = 1'b1;
        set_amt(1, 0);
        pulse_run();
        stall_v = 1'b0;
        rnd(8);
`endif
        set_amt($urandom_range(0, 63), $urandom_range(0, 63));
        pulse_run();
        rnd(80);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        rnd(3);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
